// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed seven-segment display. Watches the active-low segment and digit-enable
// bus, decodes each stable digit back to a hex nibble plus decimal point, and rebuilds the 32-bit word.
module seven_segment_capture #(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned STALE_CYCLES  = 4194304
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic [7:0]  segmentEnableN,
   input  logic [7:0]  digitEnableN,
   output logic [31:0] data,
   output logic [7:0]  pointEnable,
   output logic [7:0]  digitValid,
   output logic [7:0]  patternError,
   output logic        frameDone
);

   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned AW = $clog2(STALE_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
   localparam logic [AW-1:0] STALE_MAX  = AW'(STALE_CYCLES);

   logic [7:0]    seg_meta, seg_sync, dig_meta, dig_sync;
   logic          qualified, same_run, capture, legal;
   logic [2:0]    index;
   logic [3:0]    nibble;
   logic [10:0]   key, prev_key;
   logic [CW-1:0] settle_cnt, settle_next;
   logic [7:0]    seen, seen_next, cap_mask;
   logic [AW-1:0] age [8];

   // {legal, value} for an active-high gfedcba glyph
   function automatic logic [4:0] decode(input logic [6:0] g);
      case (g)
         7'h3F: decode = 5'h10;
         7'h06: decode = 5'h11;
         7'h5B: decode = 5'h12;
         7'h4F: decode = 5'h13;
         7'h66: decode = 5'h14;
         7'h6D: decode = 5'h15;
         7'h7D: decode = 5'h16;
         7'h07: decode = 5'h17;
         7'h7F: decode = 5'h18;
         7'h6F: decode = 5'h19;
         7'h77: decode = 5'h1A;
         7'h7C: decode = 5'h1B;
         7'h39: decode = 5'h1C;
         7'h5E: decode = 5'h1D;
         7'h79: decode = 5'h1E;
         7'h71: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         seg_meta <= '1;
         seg_sync <= '1;
         dig_meta <= '1;
         dig_sync <= '1;
      end else begin
         seg_meta <= segmentEnableN;
         seg_sync <= seg_meta;
         dig_meta <= digitEnableN;
         dig_sync <= dig_meta;
      end
   end

   always_comb begin
      qualified = $onehot(~dig_sync);
      index     = '0;
      for (int unsigned k = 0; k < 8; k++)
         if (!dig_sync[k]) index = 3'(k);
      key      = {index, seg_sync};
      // a zero count means the previous sample was unqualified, so prev_key is meaningless
      same_run = qualified && (settle_cnt != '0) && (key == prev_key);
      if (!qualified)
         settle_next = '0;
      else if (same_run)
         settle_next = (settle_cnt == SETTLE_MAX) ? SETTLE_MAX : settle_cnt + CW'(1);
      else
         settle_next = CW'(1);
      capture          = qualified && (settle_next == SETTLE_MAX) && !(same_run && settle_cnt == SETTLE_MAX);
      {legal, nibble}  = decode(~seg_sync[6:0]);
      cap_mask         = capture ? (8'(1) << index) : '0;
      seen_next        = seen | cap_mask;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         settle_cnt <= '0;
         prev_key   <= '0;
      end else begin
         settle_cnt <= settle_next;
         prev_key   <= key;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         data         <= '0;
         pointEnable  <= '0;
         patternError <= '0;
      end else if (capture) begin
         if (legal) begin
            data[{index, 2'b00} +: 4] <= nibble;
            patternError[index]       <= 1'b0;
         end else begin
            patternError[index] <= 1'b1;
         end
         pointEnable[index] <= ~seg_sync[7];
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         digitValid <= '0;
         for (int unsigned k = 0; k < 8; k++) age[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < 8; k++) begin
            if (cap_mask[k]) begin
               age[k]        <= '0;
               digitValid[k] <= 1'b1;
            end else if (age[k] != STALE_MAX) begin
               age[k] <= age[k] + AW'(1);
               if (age[k] == STALE_MAX - AW'(1)) digitValid[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         seen      <= '0;
         frameDone <= 1'b0;
      end else if (seen_next == '1) begin
         seen      <= '0;
         frameDone <= 1'b1;
      end else begin
         seen      <= seen_next;
         frameDone <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed scenarios plus random bus traffic, checked every cycle
// against a history-based model of the capture rules.
module tb_seven_segment_capture;

   localparam int unsigned S       = 16;
   localparam int unsigned STALE_B = 64;

   logic        clock = 1'b0;
   logic        resetN;
   logic [7:0]  segmentEnableN, digitEnableN;
   logic [31:0] data_a, data_b;
   logic [7:0]  point_a, point_b, valid_a, valid_b, err_a, err_b;
   logic        frame_a, frame_b;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // reference state
   logic [15:0] hist [$];
   logic [31:0] m_data;
   logic [7:0]  m_point, m_err, m_ever, m_seen;
   logic        m_frame;
   int          m_last [8];

   always #5 clock = ~clock;

   seven_segment_capture #(.SETTLE_CYCLES(S)) dut_a (
      .clock(clock), .resetN(resetN), .segmentEnableN(segmentEnableN), .digitEnableN(digitEnableN),
      .data(data_a), .pointEnable(point_a), .digitValid(valid_a), .patternError(err_a), .frameDone(frame_a));

   seven_segment_capture #(.SETTLE_CYCLES(S), .STALE_CYCLES(STALE_B)) dut_b (
      .clock(clock), .resetN(resetN), .segmentEnableN(segmentEnableN), .digitEnableN(digitEnableN),
      .data(data_b), .pointEnable(point_b), .digitValid(valid_b), .patternError(err_b), .frameDone(frame_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] digit_en(input int k);
      return ~(8'(1) << k);
   endfunction

   function automatic logic [15:0] hget(input int i);
      return (i >= 0 && i < hist.size()) ? hist[i] : 16'hFFFF;
   endfunction

   task automatic model_clear();
      hist.delete();
      m_data = '0; m_point = '0; m_err = '0; m_ever = '0; m_seen = '0; m_frame = 1'b0;
      for (int k = 0; k < 8; k++) m_last[k] = 0;
   endtask

   // A digit is captured at edge n when the bus value seen at edges n-2 .. n-1-S is one qualified
   // value and the value at edge n-2-S was something else.
   task automatic model_edge();
      logic [15:0] v;
      logic        cap;
      int          n, k;
      bit          found;
      hist.push_back({digitEnableN, segmentEnableN});
      n       = hist.size() - 1;
      m_frame = 1'b0;
      v       = hget(n - 2);
      cap     = ($countones(~v[15:8]) == 1);
      for (int j = 1; j < S; j++) if (hget(n - 2 - j) != v) cap = 1'b0;
      if (hget(n - 2 - S) == v) cap = 1'b0;
      if (cap) begin
         k = 0;
         for (int i = 0; i < 8; i++) if (!v[8 + i]) k = i;
         found = 0;
         for (int g = 0; g < 16; g++)
            if (glyph_tab[g] == ~v[6:0]) begin
               found = 1;
               m_data[4*k +: 4] = 4'(g);
            end
         m_err[k]   = !found;
         m_point[k] = ~v[7];
         m_ever[k]  = 1'b1;
         m_last[k]  = n;
         m_seen[k]  = 1'b1;
         if (m_seen == 8'hFF) begin
            m_frame = 1'b1;
            m_seen  = '0;
         end
      end
   endtask

   task automatic tick();
      logic [7:0] exp_vb;
      int         n;
      @(posedge clock);
      model_edge();
      #1;
      n = hist.size() - 1;
      for (int k = 0; k < 8; k++) exp_vb[k] = m_ever[k] && ((n - m_last[k]) < STALE_B);
      if (frame_a) pulses++;
      check("data", data_a, m_data);
      check("point", 32'(point_a), 32'(m_point));
      check("valid", 32'(valid_a), 32'(m_ever));
      check("error", 32'(err_a), 32'(m_err));
      check("frame", 32'(frame_a), 32'(m_frame));
      check("data_b", data_b, m_data);
      check("point_b", 32'(point_b), 32'(m_point));
      check("valid_b", 32'(valid_b), 32'(exp_vb));
      check("error_b", 32'(err_b), 32'(m_err));
      check("frame_b", 32'(frame_b), 32'(m_frame));
   endtask

   task automatic drive(input logic [7:0] dig, input logic [7:0] seg, input int cycles);
      digitEnableN   = dig;
      segmentEnableN = seg;
      repeat (cycles) tick();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"}, data_a | data_b, 32'h0);
      check({tag, "_point"}, 32'(point_a | point_b), 32'h0);
      check({tag, "_valid"}, 32'(valid_a | valid_b), 32'h0);
      check({tag, "_error"}, 32'(err_a | err_b), 32'h0);
      check({tag, "_frame"}, 32'(frame_a | frame_b), 32'h0);
   endtask

   task automatic do_reset();
      #1 resetN = 1'b0;
      #1 check_zero("async_reset");
      model_clear();
      #2 resetN = 1'b1;
   endtask

   initial begin
      int lat;
      logic [7:0] dig, seg;
      resetN = 1'b0;
      segmentEnableN = 8'hFF;
      digitEnableN   = 8'hFF;
      model_clear();
      repeat (2) @(posedge clock);
      #1 check_zero("reset");
      resetN = 1'b1;

      // digits 0..7 show 1..8
      pulses = 0;
      for (int d = 0; d < 8; d++) drive(digit_en(d), {1'b1, ~glyph_tab[d+1]}, 32);
      check("t1_data", data_a, 32'h87654321);
      check("t1_valid", 32'(valid_a), 32'hFF);
      check("t1_error", 32'(err_a), 32'h00);
      check("t1_pulses", 32'(pulses), 32'd1);

      // short run is ignored, full run lands exactly 2+S edges after the change
      drive(digit_en(3), {1'b1, ~glyph_tab[10]}, S - 1);
      digitEnableN   = digit_en(3);
      segmentEnableN = {1'b1, ~glyph_tab[9]};
      lat = 0;
      while (lat < 60 && data_a[15:12] == 4'h4) begin
         tick();
         lat++;
      end
      check("t2_nibble", 32'(data_a[15:12]), 32'h9);
      check("t2_latency", 32'(lat), 32'(2 + S));
      drive(digit_en(3), {1'b1, ~glyph_tab[9]}, 8);

      // overlap and blanking never capture
      drive(8'hF3, 8'(($urandom)), 100);
      drive(8'hFF, 8'(($urandom)), 100);
      check("t3_data", data_a, 32'h87659321);
      check("t3_error", 32'(err_a), 32'h00);

      // all segments lit, then an illegal glyph
      drive(digit_en(5), 8'h00, 32);
      check("t4_nibble", 32'(data_a[23:20]), 32'h8);
      check("t4_point", 32'(point_a[5]), 32'h1);
      drive(digit_en(5), 8'hFE, 32);
      check("t4_error", 32'(err_a[5]), 32'h1);
      check("t4_keep", 32'(data_a[23:20]), 32'h8);
      check("t4_point_off", 32'(point_a[5]), 32'h0);

      // staleness in the short-timeout instance
      check("t5_stale_before", 32'(valid_b[2]), 32'h0);
      digitEnableN   = digit_en(2);
      segmentEnableN = {1'b1, ~glyph_tab[12]};
      lat = 0;
      while (lat < 60 && !valid_b[2]) begin
         tick();
         lat++;
      end
      check("t5_captured", 32'(valid_b[2]), 32'h1);
      digitEnableN   = digit_en(6);
      segmentEnableN = {1'b1, ~glyph_tab[6]};
      lat = 0;
      while (lat < 200 && valid_b[2]) begin
         tick();
         lat++;
      end
      check("t5_stale_age", 32'(lat), 32'(STALE_B));
      check("t5_valid_a", 32'(valid_a[2]), 32'h1);

      // reset part-way through a frame
      for (int d = 0; d < 4; d++) drive(digit_en(d), {1'b1, ~glyph_tab[$urandom_range(0, 15)]}, 24);
      do_reset();
      pulses = 0;
      for (int d = 0; d < 7; d++) drive(digit_en(d), {1'b1, ~glyph_tab[$urandom_range(0, 15)]}, 24);
      check("t6_no_frame", 32'(pulses), 32'd0);
      drive(digit_en(7), {1'b1, ~glyph_tab[$urandom_range(0, 15)]}, 24);
      check("t6_frame", 32'(pulses), 32'd1);

      // random traffic
      for (int i = 0; i < 250; i++) begin
         case ($urandom_range(0, 9))
            0: dig = 8'hFF;
            1: dig = digit_en($urandom_range(0, 3)) & digit_en($urandom_range(4, 7));
            2: dig = digitEnableN;
            default: dig = digit_en($urandom_range(0, 7));
         endcase
         if ($urandom_range(0, 3) != 0) seg = {1'($urandom), ~glyph_tab[$urandom_range(0, 15)]};
         else seg = 8'($urandom);
         if ($urandom_range(0, 59) == 0) do_reset();
         drive(dig, seg, $urandom_range(1, 2 * S + 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
